// File: rtl/score_ctrl_if.sv
// Button/clear inputs and score/grant/busy outputs of the score controller.
interface score_ctrl_if #(
  parameter int unsigned BW = 7
);
  logic          btn_up_a_i;
  logic          btn_dn_a_i;
  logic          btn_up_b_i;
  logic          btn_dn_b_i;
  logic          clr_i;
  logic [BW-1:0] score_a_o;
  logic [BW-1:0] score_b_o;
  logic [3:0]    grant_o;
  logic          busy_o;

  modport master (
    output btn_up_a_i, btn_dn_a_i, btn_up_b_i, btn_dn_b_i, clr_i,
    input  score_a_o, score_b_o, grant_o, busy_o
  );

  modport slave (
    input  btn_up_a_i, btn_dn_a_i, btn_up_b_i, btn_dn_b_i, clr_i,
    output score_a_o, score_b_o, grant_o, busy_o
  );
endinterface

// File: rtl/score_ctrl.sv
// Two-team scoreboard: synchronised button edges, round-robin arbitration, one score update per cycle.
// Define SCORE_WRAP_EN to wrap scores at 0/MAX instead of saturating.
module score_ctrl #(
  parameter int unsigned BW  = 7,
  parameter int unsigned MAX = 99
) (
  input logic         clk_i,
  input logic         rst_n_i,
  score_ctrl_if.slave bus
);
  localparam int unsigned NSRC = 4;

  typedef enum logic {IDLE, APPLY} state_t;

  state_t          state, state_nxt;
  logic [NSRC-1:0] btn, sync1, sync2, prev, rise;
  logic [NSRC-1:0] pending, pending_nxt;
  logic [NSRC-1:0] grant, grant_nxt, pick;
  logic [1:0]      ptr, ptr_nxt, ptr_pick, idx;
  logic            found;
  logic [BW-1:0]   score_a, score_b, score_a_nxt, score_b_nxt;

  function automatic logic [BW-1:0] inc(input logic [BW-1:0] v);
`ifdef SCORE_WRAP_EN
    return (v >= BW'(MAX)) ? '0 : v + BW'(1);
`else
    return (v >= BW'(MAX)) ? BW'(MAX) : v + BW'(1);
`endif
  endfunction

  function automatic logic [BW-1:0] dec(input logic [BW-1:0] v);
`ifdef SCORE_WRAP_EN
    return (v == '0) ? BW'(MAX) : v - BW'(1);
`else
    return (v == '0) ? '0 : v - BW'(1);
`endif
  endfunction

  assign btn  = {bus.btn_dn_b_i, bus.btn_up_b_i, bus.btn_dn_a_i, bus.btn_up_a_i};
  assign rise = sync2 & ~prev;

  // Two-flop synchroniser plus previous-sample register for edge detection
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Round-robin pick: first pending source at or after ptr
  always_comb begin
    pick     = '0;
    ptr_pick = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      idx = ptr + 2'(k);
      if (!found && pending[idx]) begin
        found    = 1'b1;
        pick     = NSRC'(1) << idx;
        ptr_pick = idx + 2'd1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = '0;
    ptr_nxt     = ptr;
    pending_nxt = pending;
    score_a_nxt = score_a;
    score_b_nxt = score_b;

    case (state)
      IDLE:    if (|pending) state_nxt = APPLY;
      APPLY:   if (~|pending) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (|pending) begin
      grant_nxt = pick;
      ptr_nxt   = ptr_pick;
    end
    // A fresh edge on the source being granted stays pending
    pending_nxt = (pending & ~grant_nxt) | rise;

    case (grant)
      4'b0001: score_a_nxt = inc(score_a);
      4'b0010: score_a_nxt = dec(score_a);
      4'b0100: score_b_nxt = inc(score_b);
      4'b1000: score_b_nxt = dec(score_b);
      default: ;
    endcase

    if (bus.clr_i) begin
      state_nxt   = IDLE;
      grant_nxt   = '0;
      ptr_nxt     = '0;
      pending_nxt = '0;
      score_a_nxt = '0;
      score_b_nxt = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      grant   <= '0;
      ptr     <= '0;
      pending <= '0;
      score_a <= '0;
      score_b <= '0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      ptr     <= ptr_nxt;
      pending <= pending_nxt;
      score_a <= score_a_nxt;
      score_b <= score_b_nxt;
    end
  end

  assign bus.score_a_o = score_a;
  assign bus.score_b_o = score_b;
  assign bus.grant_o   = grant;
  assign bus.busy_o    = (|pending) || (state == APPLY);
endmodule

// File: tb/tb_score_ctrl.sv
// Directed bench for score_ctrl: latency, arbitration order, limits, clear and reset.
module tb_score_ctrl;
  localparam int unsigned BW  = 7;
  localparam int unsigned MAX = 99;
`ifdef SCORE_WRAP_EN
  localparam int unsigned EXP_B110 = 10;
  localparam int unsigned EXP_DN0  = MAX;
`else
  localparam int unsigned EXP_B110 = MAX;
  localparam int unsigned EXP_DN0  = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] btn;
  logic       clr;
  int         checks;
  int         errors;
  logic       seen;

  score_ctrl_if #(.BW(BW)) bus ();

  assign bus.btn_up_a_i = btn[0];
  assign bus.btn_dn_a_i = btn[1];
  assign bus.btn_up_b_i = btn[2];
  assign bus.btn_dn_b_i = btn[3];
  assign bus.clr_i      = clr;

  score_ctrl #(.BW(BW), .MAX(MAX)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press a button long enough to be seen, then wait until it has been applied
  task automatic press(input int src);
    btn[src] = 1'b1;
    step(3);
    btn[src] = 1'b0;
    step(4);
  endtask

  task automatic clear_all();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    btn    = '0;
    clr    = 1'b0;
    step(2);
    check("rst_score_a", 32'(bus.score_a_o), 0);
    check("rst_score_b", 32'(bus.score_b_o), 0);
    check("rst_grant",   32'(bus.grant_o), 0);
    check("rst_busy",    32'(bus.busy_o), 0);
    rst_n = 1'b1;
    step(2);

    // Latency: pending at edge 3, grant at edge 4, score at edge 5
    btn[0] = 1'b1;
    step(3);
    check("lat_busy_e3",  32'(bus.busy_o), 1);
    check("lat_grant_e3", 32'(bus.grant_o), 0);
    btn[0] = 1'b0;
    step(1);
    check("lat_grant_e4", 32'(bus.grant_o), 1);
    check("lat_a_e4",     32'(bus.score_a_o), 0);
    step(1);
    check("lat_a_e5",     32'(bus.score_a_o), 1);
    check("lat_grant_e5", 32'(bus.grant_o), 0);
    step(4);
    check("lat_busy_end", 32'(bus.busy_o), 0);
    check("lat_a_end",    32'(bus.score_a_o), 1);

    // Button held through reset yields exactly one request
    btn[2] = 1'b1;
    rst_n  = 1'b0;
    step(2);
    check("hold_rst_a", 32'(bus.score_a_o), 0);
    rst_n = 1'b1;
    step(10);
    check("hold_b_once", 32'(bus.score_b_o), 1);
    check("hold_a",      32'(bus.score_a_o), 0);
    btn[2] = 1'b0;
    step(3);

    // Four simultaneous requests, pointer left at source 0
    clear_all();
    check("clr_b", 32'(bus.score_b_o), 0);
    for (int i = 0; i < 5; i++) press(0);
    for (int i = 0; i < 6; i++) press(2);
    press(3);
    check("rr_pre_a", 32'(bus.score_a_o), 5);
    check("rr_pre_b", 32'(bus.score_b_o), 5);
    btn = 4'hF;
    step(3);
    btn = 4'h0;
    step(1);
    check("rr_g0", 32'(bus.grant_o), 32'h1);
    step(1);
    check("rr_g1", 32'(bus.grant_o), 32'h2);
    check("rr_a_mid", 32'(bus.score_a_o), 6);
    step(1);
    check("rr_g2", 32'(bus.grant_o), 32'h4);
    step(1);
    check("rr_g3", 32'(bus.grant_o), 32'h8);
    step(1);
    check("rr_g_idle", 32'(bus.grant_o), 0);
    step(3);
    check("rr_final_a", 32'(bus.score_a_o), 5);
    check("rr_final_b", 32'(bus.score_b_o), 5);
    check("rr_busy",    32'(bus.busy_o), 0);

    // Down at zero
    clear_all();
    press(1);
    check("dn_at_zero", 32'(bus.score_a_o), EXP_DN0);

    // 110 up presses on B
    clear_all();
    for (int i = 0; i < 110; i++) begin
      btn[2] = 1'b1;
      step(2);
      btn[2] = 1'b0;
      step(2);
    end
    step(6);
    check("b_110_ups", 32'(bus.score_b_o), EXP_B110);

    // Clear while a request is pending
    clear_all();
    for (int i = 0; i < 7; i++) press(0);
    for (int i = 0; i < 3; i++) press(2);
    check("clr_pre_a", 32'(bus.score_a_o), 7);
    check("clr_pre_b", 32'(bus.score_b_o), 3);
    btn[0] = 1'b1;
    step(3);
    check("clr_pending_busy", 32'(bus.busy_o), 1);
    btn[0] = 1'b0;
    clr    = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_a",     32'(bus.score_a_o), 0);
    check("clr_b2",    32'(bus.score_b_o), 0);
    check("clr_grant", 32'(bus.grant_o), 0);
    check("clr_busy",  32'(bus.busy_o), 0);
    step(5);
    check("clr_a_later",     32'(bus.score_a_o), 0);
    check("clr_grant_later", 32'(bus.grant_o), 0);

    // Reset during an in-flight update
    for (int i = 0; i < 20; i++) press(0);
    check("rst_pre_a", 32'(bus.score_a_o), 20);
    btn[0] = 1'b1;
    step(3);
    btn[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step(1);
      if (bus.grant_o == 4'b0001) seen = 1'b1;
    end
    check("rst_grant_seen", 32'(seen), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_a",     32'(bus.score_a_o), 0);
    check("rst_mid_grant", 32'(bus.grant_o), 0);
    check("rst_mid_busy",  32'(bus.busy_o), 0);
    step(1);
    rst_n = 1'b1;
    step(10);
    check("rst_after_a", 32'(bus.score_a_o), 0);
    check("rst_after_b", 32'(bus.score_b_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
